ram_port_arbiter: RTL and testbench

Shares the single 64x16 data RAM and its bidirectional data bus between two requesters: the CPU data port (store/load traffic from the datapath) and the loader/debug port that preloads or inspects RAM. It owns the RAM control pins (address, read enable, write enable) and the only tristate driver on the RAM data bus. It sequences each access as a multi-cycle read or write, returning a one-cycle acknowledge to the winning requester, and sits between the CPU wrapper and the RAM.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_port_arbiter_if.sv | 43 ++++
 rtl/rr_arb2.sv | 31 +++
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter slice.
// Holds the FSM state encoding, the owner encoding used by the arbiter and
// the round-robin picker, and the default RAM geometry (64 words x 16 bits).
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Requester identities; also the encoding of the last-served pointer.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request/acknowledge bundle between the two RAM requesters and the arbiter.
// Ports (per requester, cpu_* and ldr_*):
//   *_req    request, held high until the matching ack
//   *_we     1 = write, 0 = read
//   *_addr   word address
//   *_wdata  write data
//   *_ack    one-cycle completion pulse from the arbiter
//   *_rdata  read data, valid with ack and held until the next read completes
// Modports: master = requester side, slave = arbiter side.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_ack;
    logic [DATA_W-1:0] ldr_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker (purely combinational).
// Ports:
//   req0         request from the CPU port (id OWN_CPU)
//   req1         request from the loader port (id OWN_LDR)
//   last_served  id of the port served most recently
//   grant_valid  at least one request is present
//   grant_id     id of the winning port
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic grant_valid,
    output logic grant_id
);

    // A lone request always wins; on a tie the port not served last wins,
    // which bounds starvation at one transaction.
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_served;
        end else if (req1) begin
            grant_id = OWN_LDR;
        end else begin
            grant_id = OWN_CPU;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single data RAM and its bidirectional bus between the CPU data
// port and the loader/debug port. Each access is sequenced as
// IDLE -> WRITE -> DONE or IDLE -> READ (RD_LAT cycles) -> DONE.
// Ports:
//   clk_main   system clock, rising edge
//   reset      synchronous, active-high
//   bus        requester bundle (slave side)
//   ram_addr   RAM address (registered)
//   ram_re     RAM read enable (registered)
//   ram_we     RAM write enable (registered)
//   ram_data   RAM data bus, driven only while in WRITE
//   busy       high whenever the FSM is not idle
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
)(
    input  logic                  clk_main,
    input  logic                  reset,
    ram_port_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_re,
    output logic                  ram_we,
    inout  wire  [DATA_W-1:0]     ram_data,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_WRITE = WRITE;
    localparam logic [1:0] S_READ  = READ;
    localparam logic [1:0] S_DONE  = DONE;

    // Counter value reached in the final READ cycle.
    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    logic [1:0]        state;
    logic              owner;
    logic              last_served;
    logic [1:0]        rd_cnt;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_en;

    logic              grant_valid;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req0        (bus.cpu_req),
        .req1        (bus.ldr_req),
        .last_served (last_served),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Steer the winning port's request fields toward the latches.
    always_comb begin
        if (grant_id == OWN_LDR) begin
            sel_we    = bus.ldr_we;
            sel_addr  = bus.ldr_addr;
            sel_wdata = bus.ldr_wdata;
        end else begin
            sel_we    = bus.cpu_we;
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
        end
    end

    // Main sequencer. ram_addr doubles as the latched address. The output
    // enable for the bus is registered alongside the state so the driver
    // turns on and off exactly with the WRITE cycle. Read data is captured
    // straight into the owner's rdata register on the edge that ends the
    // last READ cycle, so it is valid together with the ack in DONE.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state         <= S_IDLE;
            owner         <= OWN_CPU;
            last_served   <= OWN_LDR;
            rd_cnt        <= 2'd0;
            wdata_q       <= '0;
            drive_en      <= 1'b0;
            ram_addr      <= '0;
            ram_re        <= 1'b0;
            ram_we        <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.ldr_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.ldr_rdata <= '0;
        end else begin
            bus.cpu_ack <= 1'b0;
            bus.ldr_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant_id;
                        ram_addr <= sel_addr;
                        wdata_q  <= sel_wdata;
                        rd_cnt   <= 2'd0;
                        if (sel_we) begin
                            state    <= S_WRITE;
                            ram_we   <= 1'b1;
                            drive_en <= 1'b1;
                        end else begin
                            state  <= S_READ;
                            ram_re <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    state       <= S_DONE;
                    ram_we      <= 1'b0;
                    drive_en    <= 1'b0;
                    bus.cpu_ack <= (owner == OWN_CPU);
                    bus.ldr_ack <= (owner == OWN_LDR);
                end
                S_READ: begin
                    if (rd_cnt == LAST_CNT) begin
                        state       <= S_DONE;
                        ram_re      <= 1'b0;
                        bus.cpu_ack <= (owner == OWN_CPU);
                        bus.ldr_ack <= (owner == OWN_LDR);
                        if (owner == OWN_LDR) begin
                            bus.ldr_rdata <= ram_data;
                        end else begin
                            bus.cpu_rdata <= ram_data;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    last_served <= owner;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_data = drive_en ? wdata_q : {DATA_W{1'bz}};
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with RD_LAT = 2.
// A small RAM model answers reads in the last READ cycle. Stimulus pushes
// the expected rdata of every transaction into a per-port queue; a monitor
// pops and compares whenever an ack appears, and also checks tie ordering,
// that the other port's rdata is undisturbed and that the bus floats
// whenever nobody should drive it.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int RD_LAT = 2;

    logic        clk_main = 1'b0;
    logic        reset;
    logic [5:0]  ram_addr;
    logic        ram_re;
    logic        ram_we;
    logic        busy;
    wire  [15:0] ram_data;

    ram_port_arbiter_if #(.ADDR_W(6), .DATA_W(16)) bus ();

    ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .bus      (bus.slave),
        .ram_addr (ram_addr),
        .ram_re   (ram_re),
        .ram_we   (ram_we),
        .ram_data (ram_data),
        .busy     (busy)
    );

    always #5 clk_main = ~clk_main;

    // RAM model: stores on ram_we, drives read data in the final READ cycle.
    logic [15:0] mem [64];
    logic [1:0]  re_cnt = 2'd0;
    logic        tb_drive;
    int          cyc = 0;

    always @(posedge clk_main) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_data;
        re_cnt <= ram_re ? re_cnt + 2'd1 : 2'd0;
    end

    assign tb_drive = ram_re && (re_cnt == 2'(RD_LAT - 1));
    assign ram_data = tb_drive ? mem[ram_addr] : 16'hzzzz;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] cpu_q [$];
    logic [15:0] ldr_q [$];
    logic        order_q [$];
    logic [15:0] cur_cpu = 16'h0;
    logic [15:0] cur_ldr = 16'h0;
    logic [15:0] last_cpu = 16'h0;
    logic [15:0] last_ldr = 16'h0;
    int          re_run_cur = 0;
    int          last_re_run = 0;
    int          lat;
    int          lat2;
    logic        seen;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic reportMissing(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: event absent, expected present", name);
    endtask

    // One transaction on one port; hold keeps req high after the ack for a
    // back-to-back follow-up, drop_early releases req right after the grant.
    task automatic applyStimulus(input logic port, input logic we,
                                 input logic [5:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] rd_exp, input logic hold,
                                 input logic drop_early, output int latency);
        logic [15:0] expv;
        logic        got;
        int          start;
        got = 1'b0;
        if (we) begin
            expv = (port == OWN_LDR) ? last_ldr : last_cpu;
        end else begin
            expv = rd_exp;
            if (port == OWN_LDR) last_ldr = rd_exp;
            else                 last_cpu = rd_exp;
        end
        if (port == OWN_LDR) begin
            ldr_q.push_back(expv);
            bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata; bus.ldr_req = 1'b1;
        end else begin
            cpu_q.push_back(expv);
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        end
        start = cyc;
        if (drop_early) begin
            @(posedge clk_main); #1;
            if (port == OWN_LDR) bus.ldr_req = 1'b0;
            else                 bus.cpu_req = 1'b0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_main);
            if ((port == OWN_LDR) ? bus.ldr_ack : bus.cpu_ack) begin
                got = 1'b1;
                break;
            end
        end
        latency = cyc - start;
        if (!got) begin
            reportMissing((port == OWN_LDR) ? "ldr_ack_timeout" : "cpu_ack_timeout");
            latency = -1;
        end
        if (!hold || !got) begin
            @(posedge clk_main); #1;
            if (port == OWN_LDR) bus.ldr_req = 1'b0;
            else                 bus.cpu_req = 1'b0;
        end
    endtask

    task automatic monitorCycle();
        logic [15:0] e;
        logic        o;
        @(negedge clk_main);
        if (reset) begin
            cur_cpu = 16'h0;
            cur_ldr = 16'h0;
        end
        if (bus.cpu_ack || bus.ldr_ack)
            checkOutput("ack_onehot", 16'(bus.cpu_ack & bus.ldr_ack), 16'h0);
        if (bus.cpu_ack) begin
            if (cpu_q.size() == 0) begin
                reportMissing("cpu_ack_expected_entry");
            end else begin
                e = cpu_q.pop_front();
                checkOutput("cpu_rdata", bus.cpu_rdata, e);
                cur_cpu = e;
                checkOutput("ldr_rdata_held", bus.ldr_rdata, cur_ldr);
                if (order_q.size() != 0) begin
                    o = order_q.pop_front();
                    checkOutput("grant_order", 16'(OWN_CPU), 16'(o));
                end
            end
        end
        if (bus.ldr_ack) begin
            if (ldr_q.size() == 0) begin
                reportMissing("ldr_ack_expected_entry");
            end else begin
                e = ldr_q.pop_front();
                checkOutput("ldr_rdata", bus.ldr_rdata, e);
                cur_ldr = e;
                checkOutput("cpu_rdata_held", bus.cpu_rdata, cur_cpu);
                if (order_q.size() != 0) begin
                    o = order_q.pop_front();
                    checkOutput("grant_order", 16'(OWN_LDR), 16'(o));
                end
            end
        end
        if (!ram_we && !tb_drive)
            checkOutput("bus_hiz", ram_data, 16'hzzzz);
        if (ram_re) begin
            re_run_cur++;
        end else if (re_run_cur != 0) begin
            last_re_run = re_run_cur;
            re_run_cur = 0;
        end
    endtask

    task automatic pulseReset();
        @(posedge clk_main); #1;
        reset = 1'b1;
        last_cpu = 16'h0;
        last_ldr = 16'h0;
        @(posedge clk_main); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        fork
            forever monitorCycle();
            begin
                // Reset state.
                repeat (2) @(posedge clk_main);
                @(negedge clk_main);
                checkOutput("rst_ram_re", 16'(ram_re), 16'h0);
                checkOutput("rst_ram_we", 16'(ram_we), 16'h0);
                checkOutput("rst_ram_addr", 16'(ram_addr), 16'h0);
                checkOutput("rst_busy", 16'(busy), 16'h0);
                checkOutput("rst_cpu_ack", 16'(bus.cpu_ack), 16'h0);
                checkOutput("rst_ldr_ack", 16'(bus.ldr_ack), 16'h0);
                checkOutput("rst_cpu_rdata", bus.cpu_rdata, 16'h0);
                checkOutput("rst_ldr_rdata", bus.ldr_rdata, 16'h0);
                @(posedge clk_main); #1;
                reset = 1'b0;

                // Tie straight out of reset: CPU first, loader second.
                order_q.push_back(OWN_CPU);
                order_q.push_back(OWN_LDR);
                fork
                    applyStimulus(OWN_CPU, 1'b1, 6'd1, 16'h1111, 16'h0, 1'b0, 1'b0, lat);
                    applyStimulus(OWN_LDR, 1'b1, 6'd2, 16'h2222, 16'h0, 1'b0, 1'b0, lat2);
                join

                // CPU write 0xBEEF to addr 5 with cycle-level bus checks.
                fork
                    applyStimulus(OWN_CPU, 1'b1, 6'd5, 16'hBEEF, 16'h0, 1'b0, 1'b0, lat);
                    begin
                        seen = 1'b0;
                        for (int i = 0; i < 10; i++) begin
                            @(negedge clk_main);
                            if (busy) begin
                                seen = 1'b1;
                                break;
                            end
                        end
                        checkOutput("wr_busy_seen", 16'(seen), 16'h1);
                        checkOutput("wr_ram_we", 16'(ram_we), 16'h1);
                        checkOutput("wr_ram_re", 16'(ram_re), 16'h0);
                        checkOutput("wr_ram_addr", 16'(ram_addr), 16'h0005);
                        checkOutput("wr_ram_data", ram_data, 16'hBEEF);
                        @(negedge clk_main);
                        checkOutput("wr_we_one_cycle", 16'(ram_we), 16'h0);
                        checkOutput("wr_cpu_ack", 16'(bus.cpu_ack), 16'h1);
                    end
                join
                checkOutput("wr_latency", 16'(lat), 16'd2);

                // Loader read of addr 5: two READ cycles, ack in cycle 3.
                applyStimulus(OWN_LDR, 1'b0, 6'd5, 16'h0, 16'hBEEF, 1'b0, 1'b0, lat);
                checkOutput("rd_latency", 16'(lat), 16'd3);
                checkOutput("rd_re_cycles", 16'(last_re_run), 16'd2);

                // Both held high from reset: grants alternate C, L, C, L.
                pulseReset();
                order_q.push_back(OWN_CPU);
                order_q.push_back(OWN_LDR);
                order_q.push_back(OWN_CPU);
                order_q.push_back(OWN_LDR);
                fork
                    begin
                        applyStimulus(OWN_CPU, 1'b0, 6'd5, 16'h0, 16'hBEEF, 1'b1, 1'b0, lat);
                        applyStimulus(OWN_CPU, 1'b0, 6'd1, 16'h0, 16'h1111, 1'b0, 1'b0, lat);
                    end
                    begin
                        applyStimulus(OWN_LDR, 1'b1, 6'd30, 16'h3030, 16'h0, 1'b1, 1'b0, lat2);
                        applyStimulus(OWN_LDR, 1'b1, 6'd31, 16'h3131, 16'h0, 1'b0, 1'b0, lat2);
                    end
                join

                // CPU back-to-back writes: acks three cycles apart.
                applyStimulus(OWN_CPU, 1'b1, 6'd6, 16'h0A06, 16'h0, 1'b1, 1'b0, lat);
                applyStimulus(OWN_CPU, 1'b1, 6'd7, 16'h0A07, 16'h0, 1'b0, 1'b0, lat2);
                checkOutput("b2b_first_latency", 16'(lat), 16'd2);
                checkOutput("b2b_ack_spacing", 16'(lat2), 16'd3);

                // Reset landing on the last READ cycle of a CPU read.
                bus.cpu_we = 1'b0; bus.cpu_addr = 6'd6; bus.cpu_req = 1'b1;
                seen = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk_main);
                    if (ram_re) begin
                        seen = 1'b1;
                        break;
                    end
                end
                checkOutput("rst_rd_started", 16'(seen), 16'h1);
                @(posedge clk_main); #1;
                reset = 1'b1;
                bus.cpu_req = 1'b0;
                last_cpu = 16'h0;
                last_ldr = 16'h0;
                @(negedge clk_main);
                @(negedge clk_main);
                checkOutput("midrst_ram_re", 16'(ram_re), 16'h0);
                checkOutput("midrst_busy", 16'(busy), 16'h0);
                checkOutput("midrst_cpu_ack", 16'(bus.cpu_ack), 16'h0);
                checkOutput("midrst_cpu_rdata", bus.cpu_rdata, 16'h0);
                checkOutput("midrst_bus", ram_data, 16'hzzzz);
                @(posedge clk_main); #1;
                reset = 1'b0;
                repeat (3) @(posedge clk_main);
                #1;

                // Normal CPU read after the aborted one.
                applyStimulus(OWN_CPU, 1'b0, 6'd6, 16'h0, 16'h0A06, 1'b0, 1'b0, lat);
                checkOutput("post_rst_rd_latency", 16'(lat), 16'd3);

                // Loader drops req right after its grant; ack still arrives.
                applyStimulus(OWN_LDR, 1'b0, 6'd7, 16'h0, 16'h0A07, 1'b0, 1'b1, lat);
                checkOutput("drop_rd_latency", 16'(lat), 16'd3);

                repeat (3) @(negedge clk_main);
                checkOutput("cpu_q_drained", 16'(cpu_q.size()), 16'h0);
                checkOutput("ldr_q_drained", 16'(ldr_q.size()), 16'h0);
                checkOutput("order_q_drained", 16'(order_q.size()), 16'h0);

                $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            end
        join_any
        $finish;
    end

endmodule
